// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared types and opcode constants for the SPI burst RAM slave
// Purpose: frame state encoding and the 3-bit command opcodes.
// Ports: none (package).
package spi_ram_pkg;

  localparam int OPC_WIDTH = 3;

  localparam logic [OPC_WIDTH-1:0] OPC_WR_ADDR = 3'b000;
  localparam logic [OPC_WIDTH-1:0] OPC_WR_DATA = 3'b001;
  localparam logic [OPC_WIDTH-1:0] OPC_RD_ADDR = 3'b110;
  localparam logic [OPC_WIDTH-1:0] OPC_RD_DATA = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_OPCODE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_TURN,
    ST_RD_DATA,
    ST_DROP
  } state_t;

endpackage

// File: rtl/spi_ram_burst_slave_if.sv
// rtl/spi_ram_burst_slave_if.sv - SPI pin and status bundle for the burst RAM slave
// Purpose: groups the serial pins and status outputs.
// Signals: ss_n (select, active-low), mosi (serial in), miso (serial out),
//          busy (frame in progress), err (sticky protocol error).
// Modports: slave (the RAM block), master (the SPI host / bench).
interface spi_ram_burst_slave_if;
  logic ss_n;
  logic mosi;
  logic miso;
  logic busy;
  logic err;

  modport slave (
    input  ss_n,
    input  mosi,
    output miso,
    output busy,
    output err
  );

  modport master (
    output ss_n,
    output mosi,
    input  miso,
    input  busy,
    input  err
  );
endinterface

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - word RAM with one synchronous write and one asynchronous read port
// Purpose: MEM_DEPTH x DATA_WIDTH storage; addresses at or beyond MEM_DEPTH
//          are flagged, writes to them are dropped and reads return zero.
// Ports: clk, we, waddr, wdata (write port); raddr, rdata (read port);
//        wr_bad, rd_bad (address out of range flags).
module spi_ram_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wr_bad,
  output logic                  rd_bad
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign wr_bad = int'(waddr) >= MEM_DEPTH;
  assign rd_bad = int'(raddr) >= MEM_DEPTH;

  always_ff @(posedge clk) begin
    if (we && !wr_bad) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rd_bad ? '0 : mem[raddr];

endmodule

// File: rtl/spi_ram_burst_slave.sv
// rtl/spi_ram_burst_slave.sv - SPI slave with embedded RAM and auto-incrementing bursts
// Purpose: decodes a 3-bit opcode per frame, then loads the write/read address
//          or streams words in/out of the RAM, advancing the address per word.
// Ports: clk (serial bit clock), rst (async active-high reset),
//        bus (slave modport: ss_n, mosi in; miso, busy, err out).
module spi_ram_burst_slave
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_ram_burst_slave_if.slave  bus
);

  // One shifter serves opcode, address and data fields, so it must hold the widest.
  localparam int WIDE  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAXW  = (WIDE > OPC_WIDTH) ? WIDE : OPC_WIDTH;
  localparam int CNT_W = $clog2(MAXW);

  localparam logic [CNT_W-1:0] OPC_LAST  = CNT_W'(OPC_WIDTH - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state, state_nx;
  logic [CNT_W-1:0]      bit_cnt;
  logic [MAXW-2:0]       shift_in;
  logic [MAXW-1:0]       shift_nx;
  logic [DATA_WIDTH-1:0] shift_out;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, rd_next, mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [OPC_WIDTH-1:0]  opc;
  logic                  mem_we, wr_bad, rd_bad, err_q;

  // Address advance: wraps to 0 after MEM_DEPTH-1, and any out-of-range
  // address also lands back on 0.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    if (int'(a) >= MEM_DEPTH - 1) begin
      return '0;
    end
    return a + ADDR_WIDTH'(1);
  endfunction

  // shift_nx already contains the bit being sampled this edge, so a field
  // is complete (and usable) on the posedge of its last bit.
  assign shift_nx  = {shift_in, bus.mosi};
  assign opc       = shift_nx[OPC_WIDTH-1:0];
  assign rd_next   = addr_inc(rd_addr);
  assign mem_raddr = (state == ST_RD_TURN) ? rd_addr : rd_next;
  // ss_n high on the last bit aborts the word: no write, no increment.
  assign mem_we    = !bus.ss_n && (state == ST_WR_DATA) && (bit_cnt == DATA_LAST);

  spi_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (wr_addr),
    .wdata  (shift_nx[DATA_WIDTH-1:0]),
    .raddr  (mem_raddr),
    .rdata  (mem_rdata),
    .wr_bad (wr_bad),
    .rd_bad (rd_bad)
  );

  assign bus.miso = (state == ST_RD_DATA) ? shift_out[DATA_WIDTH-1] : 1'b0;
  assign bus.busy = (state != ST_IDLE);
  assign bus.err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.ss_n) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nx = ST_START;
        ST_START: state_nx = ST_OPCODE;
        ST_OPCODE: begin
          if (bit_cnt == OPC_LAST) begin
            case (opc)
              OPC_WR_ADDR: state_nx = ST_WR_ADDR;
              OPC_WR_DATA: state_nx = ST_WR_DATA;
              OPC_RD_ADDR: state_nx = ST_RD_ADDR;
              OPC_RD_DATA: state_nx = ST_RD_TURN;
              default:     state_nx = ST_DROP;
            endcase
          end
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            state_nx = ST_DROP;
          end
        end
        ST_RD_TURN: state_nx = ST_RD_DATA;
        default:    state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      err_q     <= 1'b0;
    end else begin
      shift_in <= shift_nx[MAXW-2:0];
      if (bus.ss_n) begin
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= '0;
            err_q   <= 1'b0;
          end
          ST_OPCODE: begin
            if (bit_cnt == OPC_LAST) begin
              bit_cnt <= '0;
              if (!(opc inside {OPC_WR_ADDR, OPC_WR_DATA, OPC_RD_ADDR, OPC_RD_DATA})) begin
                err_q <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_WR_ADDR: begin
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              wr_addr <= shift_nx[ADDR_WIDTH-1:0];
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_RD_ADDR: begin
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              rd_addr <= shift_nx[ADDR_WIDTH-1:0];
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_WR_DATA: begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              wr_addr <= addr_inc(wr_addr);
              if (wr_bad) begin
                err_q <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_RD_TURN: begin
            bit_cnt   <= '0;
            shift_out <= mem_rdata;
            if (rd_bad) begin
              err_q <= 1'b1;
            end
          end
          ST_RD_DATA: begin
            // Reload on the last bit so the next word follows with no gap.
            if (bit_cnt == DATA_LAST) begin
              bit_cnt   <= '0;
              shift_out <= mem_rdata;
              rd_addr   <= rd_next;
              if (rd_bad) begin
                err_q <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + CNT_W'(1);
              shift_out <= shift_out << 1;
            end
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb/tb_spi_ram_burst_slave.sv - self-checking bench for the SPI burst RAM slave
module tb_spi_ram_burst_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_ram_burst_slave_if bus_m ();
  spi_ram_burst_slave_if bus_s ();

  spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256)) dut (
    .clk (clk), .rst (rst), .bus (bus_m)
  );
  spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  logic ss_d, mosi_d;
  int   tgt;
  assign bus_m.ss_n = (tgt == 0) ? ss_d : 1'b1;
  assign bus_s.ss_n = (tgt == 1) ? ss_d : 1'b1;
  assign bus_m.mosi = mosi_d;
  assign bus_s.mosi = mosi_d;

  logic miso, busy, err;
  assign miso = (tgt == 1) ? bus_s.miso : bus_m.miso;
  assign busy = (tgt == 1) ? bus_s.busy : bus_m.busy;
  assign err  = (tgt == 1) ? bus_s.err  : bus_m.err;

  int checks = 0;
  int failures = 0;

  // Reference model of the 256-word device: memory plus the two pointers.
  logic [7:0] ref_mem [256];
  int         ref_wr, ref_rd;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] waddr;
    int         wlen;
    logic [7:0] wd [3];
    logic [7:0] raddr;
    int         rlen;
    logic [7:0] ex [3];
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic m);
    ss_d   = s;
    mosi_d = m;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
  endtask

  task automatic frame_start(input logic [2:0] opc);
    step(1'b0, 1'($urandom));
    step(1'b0, 1'($urandom));
    send_bits(32'(opc), 3);
  endtask

  task automatic frame_end();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic wr_addr_frame(input logic [7:0] a);
    frame_start(3'b000);
    send_bits(32'(a), 8);
    send_bits($urandom, 3);
    frame_end();
    if (tgt == 0) ref_wr = int'(a);
  endtask

  task automatic rd_addr_frame(input logic [7:0] a);
    frame_start(3'b110);
    send_bits(32'(a), 8);
    send_bits($urandom, 2);
    frame_end();
    if (tgt == 0) ref_rd = int'(a);
  endtask

  task automatic wr_data_frame();
    frame_start(3'b001);
    foreach (tx_q[i]) begin
      send_bits(32'(tx_q[i]), 8);
      if (tgt == 0) begin
        ref_mem[ref_wr] = tx_q[i];
        ref_wr = (ref_wr + 1) % 256;
      end
    end
    frame_end();
  endtask

  task automatic rd_data_frame(input int n);
    logic [7:0] b;
    frame_start(3'b111);
    chk("turn_miso", 32'(miso), 32'd0);
    step(1'b0, 1'($urandom));
    rx_q.delete();
    for (int w = 0; w < n; w++) begin
      for (int i = 7; i >= 0; i--) begin
        b[i] = miso;
        step(1'b0, 1'($urandom));
      end
      rx_q.push_back(b);
    end
    frame_end();
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input int n, input bit set_addr);
    logic [7:0] exp_q[$];
    if (set_addr) rd_addr_frame(a);
    for (int j = 0; j < n; j++) exp_q.push_back(ref_mem[(ref_rd + j) % 256]);
    rd_data_frame(n);
    ref_rd = (ref_rd + n) % 256;
    for (int j = 0; j < n; j++) chk(name, 32'(rx_q[j]), 32'(exp_q[j]));
    chk({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'h10, 1, '{8'hA5, 8'h00, 8'h00}, 8'h10, 1, '{8'hA5, 8'h00, 8'h00}};
    tbl[1] = '{8'hFE, 3, '{8'h01, 8'h02, 8'h03}, 8'hFE, 3, '{8'h01, 8'h02, 8'h03}};
    tbl[2] = '{8'h00, 0, '{8'h00, 8'h00, 8'h00}, 8'h00, 1, '{8'h03, 8'h00, 8'h00}};
    tbl[3] = '{8'h7F, 2, '{8'h3C, 8'hC3, 8'h00}, 8'h7F, 2, '{8'h3C, 8'hC3, 8'h00}};

    tgt = 0; ss_d = 1'b1; mosi_d = 1'b0; rst = 1'b1;
    ref_wr = 0; ref_rd = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Fill the whole RAM in one burst so every later read has a known value.
    tx_q.delete();
    for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom));
    wr_addr_frame(8'h00);
    wr_data_frame();
    chk("fill_err", 32'(err), 32'd0);

    for (int v = 0; v < 4; v++) begin
      if (tbl[v].wlen > 0) begin
        wr_addr_frame(tbl[v].waddr);
        tx_q.delete();
        for (int j = 0; j < tbl[v].wlen; j++) tx_q.push_back(tbl[v].wd[j]);
        wr_data_frame();
      end
      rd_addr_frame(tbl[v].raddr);
      rd_data_frame(tbl[v].rlen);
      ref_rd = (ref_rd + tbl[v].rlen) % 256;
      for (int j = 0; j < tbl[v].rlen; j++) chk($sformatf("tbl%0d_w%0d", v, j), 32'(rx_q[j]), 32'(tbl[v].ex[j]));
      chk($sformatf("tbl%0d_err", v), 32'(err), 32'd0);
    end

    // Illegal opcode: error, stays busy until deselect, error cleared by next frame start.
    frame_start(3'b100);
    chk("badopc_err", 32'(err), 32'd1);
    chk("badopc_busy", 32'(busy), 32'd1);
    send_bits($urandom, 10);
    chk("drop_busy", 32'(busy), 32'd1);
    step(1'b1, 1'b0);
    chk("drop_end_busy", 32'(busy), 32'd0);
    chk("drop_err_sticky", 32'(err), 32'd1);
    step(1'b0, 1'b0);
    chk("start_err_clr", 32'(err), 32'd0);
    frame_end();
    read_check("badopc_ram", 8'h10, 1, 1'b1);

    // Deselect coincident with the last data bit aborts the word.
    wr_addr_frame(8'h20);
    frame_start(3'b001);
    send_bits(32'(8'h5A >> 1), 7);
    step(1'b1, 1'b0);
    chk("abort_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b0);
    read_check("abort_keep", 8'h20, 1, 1'b1);
    tx_q.delete();
    tx_q.push_back(8'h77);
    wr_data_frame();
    read_check("abort_next", 8'h20, 1, 1'b1);
    chk("abort_next_val", 32'(rx_q[0]), 32'h77);

    // Reset in the middle of a data word: no partial write, pointers cleared.
    wr_addr_frame(8'h30);
    frame_start(3'b001);
    send_bits($urandom, 4);
    rst = 1'b1;
    #1;
    chk("midrst_busy_async", 32'(busy), 32'd0);
    step(1'b1, 1'b0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ref_wr = 0;
    ref_rd = 0;
    read_check("midrst_ram", 8'h30, 1, 1'b1);
    read_check("midrst_rdptr", 8'h00, 2, 1'b0);

    // Randomised bursts against the reference model.
    for (int it = 0; it < 30; it++) begin
      int op, n;
      logic [7:0] a;
      op = int'($urandom_range(2, 0));
      n  = int'($urandom_range(5, 1));
      a  = 8'($urandom);
      case (op)
        0: begin
          if ($urandom_range(1, 0) == 1) wr_addr_frame(a);
          tx_q.delete();
          for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
          wr_data_frame();
        end
        1: read_check($sformatf("rnd%0d_rd", it), a, n, 1'b1);
        default: read_check($sformatf("rnd%0d_cont", it), a, n, 1'b0);
      endcase
    end

    // 200-word device: addresses 0xC8 and up are outside the array.
    tgt = 1;
    wr_addr_frame(8'hC8);
    tx_q.delete();
    tx_q.push_back(8'h55);
    wr_data_frame();
    chk("oob_wr_err", 32'(err), 32'd1);
    rd_addr_frame(8'hC8);
    chk("oob_err_clr", 32'(err), 32'd0);
    rd_data_frame(1);
    chk("oob_rd_val", 32'(rx_q[0]), 32'h00);
    chk("oob_rd_err", 32'(err), 32'd1);
    wr_addr_frame(8'hC7);
    tx_q.delete();
    tx_q.push_back(8'h99);
    wr_data_frame();
    chk("top_wr_err", 32'(err), 32'd0);
    rd_addr_frame(8'hC7);
    rd_data_frame(1);
    chk("top_rd_val", 32'(rx_q[0]), 32'h99);
    chk("top_rd_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
